// File: rtl/hog_pkg.sv
// rtl/hog_pkg.sv - shared encodings and constants for the HOG read DMA
package hog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned BOUNDARY_4K    = 4096;

endpackage

// File: rtl/hog_burst_calc.sv
// rtl/hog_burst_calc.sv - beats for the next burst: min(remaining, max burst, beats to 4 KB page end)
module hog_burst_calc
    import hog_pkg::*;
#(
    parameter int AXI_DW    = 64,
    parameter int MAX_BURST = 16
) (
    input  logic [11:0] addr,
    input  logic [31:0] beats_left,
    output logic [8:0]  burst
);

    localparam int SZ = $clog2(AXI_DW / 8);

    logic [12:0] to_boundary;
    logic [31:0] cap;

    always_comb begin
        // addr is beat aligned, so the page remainder divides exactly
        to_boundary = 13'(BOUNDARY_4K) - {1'b0, addr};
        cap = 32'(to_boundary >> SZ);
        if (cap > 32'(MAX_BURST)) begin
            cap = 32'(MAX_BURST);
        end
        if (beats_left < cap) begin
            cap = beats_left;
        end
    end

    assign burst = 9'(cap);

endmodule

// File: rtl/hog_rd_dma.sv
// rtl/hog_rd_dma.sv - AXI4 read master streaming a DDR region onto AXI-Stream in page-safe bursts
module hog_rd_dma
    import hog_pkg::*;
#(
    parameter int AXI_AW    = 32,
    parameter int AXI_DW    = 64,
    parameter int MAX_BURST = 16
) (
    input  logic              aclk,
    input  logic              arest_n,
    input  logic              start,
    input  logic              stop,
    input  logic [AXI_AW-1:0] src_addr,
    input  logic [31:0]       byte_len,
    output logic [AXI_AW-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [AXI_DW-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [AXI_DW-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic [3:0]        status
);

    localparam int SZ = $clog2(AXI_DW / 8);
    localparam logic [AXI_AW-1:0] ALIGN_MASK = ~(AXI_AW'((1 << SZ) - 1));

    state_e            state_q, state_d;
    logic [AXI_AW-1:0] addr_q, addr_d;
    logic [31:0]       beats_left_q, beats_left_d;
    logic              err_q, err_d;

    logic [8:0]        burst;
    logic [31:0]       start_beats;
    logic              in_data;
    logic              r_hs;

    hog_burst_calc #(
        .AXI_DW    (AXI_DW),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .addr       (addr_q[11:0]),
        .beats_left (beats_left_q),
        .burst      (burst)
    );

    assign start_beats = byte_len >> SZ;
    assign in_data     = (state_q == ST_DATA);
    assign r_hs        = in_data & m_axi_rvalid & m_axis_tready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d       = src_addr & ALIGN_MASK;
                    beats_left_d = start_beats;
                    err_d        = 1'b0;
                    state_d      = (start_beats == 32'd0) ? ST_DONE : ST_AR;
                end
            end
            ST_AR: begin
                // stop is only honoured at a burst end; arvalid cannot be withdrawn
                if (m_axi_arready) begin
                    addr_d       = addr_q + (AXI_AW'(burst) << SZ);
                    beats_left_d = beats_left_q - 32'(burst);
                    state_d      = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    if (m_axi_rresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    if (m_axi_rlast) begin
                        state_d = ((beats_left_q == 32'd0) || stop) ? ST_DONE : ST_AR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            err_q        <= err_d;
        end
    end

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = (state_q == ST_AR) ? 8'(burst - 9'd1) : 8'd0;
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (state_q == ST_AR);

    // R to stream is a pure pass-through so tready backpressure reaches rready in the same cycle
    assign m_axi_rready  = in_data & m_axis_tready;
    assign m_axis_tvalid = in_data & m_axi_rvalid;
    assign m_axis_tdata  = in_data ? m_axi_rdata : '0;
    assign m_axis_tlast  = in_data & m_axi_rvalid & m_axi_rlast & (beats_left_q == 32'd0);

    assign done   = (state_q == ST_DONE);
    assign busy   = (state_q != ST_IDLE);
    assign err    = err_q;
    assign status = {state_d, state_q};

endmodule

// File: tb/tb_hog_rd_dma.sv
// tb/tb_hog_rd_dma.sv - scoreboard bench for hog_rd_dma with a single-outstanding AXI read slave model
module tb_hog_rd_dma;

    logic        aclk = 1'b0;
    logic        arest_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] byte_len = '0;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [63:0] rdata = 64'hDEAD_BEEF_CAFE_F00D;
    logic [1:0]  rresp = 2'b00;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready = 1'b1;
    logic        done;
    logic        busy;
    logic        err;
    logic [3:0]  status;

    always #5 aclk = ~aclk;

    hog_rd_dma #(
        .AXI_AW    (32),
        .AXI_DW    (64),
        .MAX_BURST (16)
    ) dut (
        .aclk          (aclk),
        .arest_n       (arest_n),
        .start         (start),
        .stop          (stop),
        .src_addr      (src_addr),
        .byte_len      (byte_len),
        .m_axi_araddr  (araddr),
        .m_axi_arlen   (arlen),
        .m_axi_arsize  (arsize),
        .m_axi_arburst (arburst),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rlast   (rlast),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .done          (done),
        .busy          (busy),
        .err           (err),
        .status        (status)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];
    logic [63:0] exp_data[$];
    logic        exp_last[$];
    logic        exp_err = 1'b0;

    int beat_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    task automatic exp_burst(input logic [31:0] a, input int beats, input logic last_of_xfer);
        logic [31:0] ba;
        exp_ar_addr.push_back(a);
        exp_ar_len.push_back(8'(beats - 1));
        for (int i = 0; i < beats; i++) begin
            ba = a + 32'(i * 8);
            exp_data.push_back({ba, ~ba});
            exp_last.push_back(last_of_xfer && (i == beats - 1));
        end
    endtask

    // Slave model: acts on handshakes observed at the preceding negedge
    logic        stall_en = 1'b0;
    logic [31:0] s_addr = '0;
    int          s_rem = 0;
    logic        s_pend = 1'b0;
    int          beat_idx = 0;
    int          err_beat = -1;
    logic        s_ar_hs, s_r_hs;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;

    always begin
        @(negedge aclk);
        s_ar_hs  = arvalid && arready;
        s_r_hs   = rvalid && rready;
        s_araddr = araddr;
        s_arlen  = arlen;
        @(posedge aclk);
        #1;
        if (!arest_n) begin
            s_pend  = 1'b0;
            rvalid  = 1'b0;
            arready = 1'b0;
            rlast   = 1'b0;
            rresp   = 2'b00;
        end else begin
            if (s_r_hs) begin
                s_addr = s_addr + 32'd8;
                s_rem--;
                beat_idx++;
                if (s_rem == 0) s_pend = 1'b0;
            end
            if (s_ar_hs) begin
                s_addr = s_araddr;
                s_rem  = int'(s_arlen) + 1;
                s_pend = 1'b1;
            end
            if (s_pend) begin
                if (!rvalid || s_r_hs) rvalid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                rvalid = 1'b0;
            end
            rdata   = {s_addr, ~s_addr};
            rlast   = s_pend && (s_rem == 1);
            rresp   = (beat_idx == err_beat) ? 2'b10 : 2'b00;
            arready = arvalid && !s_pend && (stall_en ? ($urandom_range(0, 2) == 0) : 1'b1);
            tready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    always @(negedge aclk) begin
        if (arest_n) begin
            if (prev_stall && arvalid) begin
                chk("araddr_stable", 64'(araddr), 64'(prev_addr));
                chk("arlen_stable", 64'(arlen), 64'(prev_len));
            end
            prev_stall = arvalid && !arready;
            prev_addr  = araddr;
            prev_len   = arlen;
            if (arvalid && arready) begin
                if (exp_ar_addr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ar: got addr 0x%0h, required no burst", araddr);
                end else begin
                    chk("araddr", 64'(araddr), 64'(exp_ar_addr.pop_front()));
                    chk("arlen", 64'(arlen), 64'(exp_ar_len.pop_front()));
                end
            end
            if (tvalid && tready) begin
                beat_cnt++;
                if (exp_data.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got tdata 0x%0h, required no beat", tdata);
                end else begin
                    chk("tdata", tdata, exp_data.pop_front());
                    chk("tlast", 64'(tlast), 64'(exp_last.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                chk("err_at_done", 64'(err), 64'(exp_err));
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic new_test();
        done_cnt = 0;
        beat_cnt = 0;
        beat_idx = 0;
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] l);
        src_addr = a;
        byte_len = l;
        start    = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_beats(input string name, input int n);
        int k = 0;
        while (beat_cnt < n && k < 2000) begin
            @(posedge aclk);
            #1;
            k++;
        end
        chk({name, "_beats_reached"}, 64'(beat_cnt >= n), 64'd1);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(posedge aclk);
            #1;
            k++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic finish_test(input string name, input int beats);
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        chk({name, "_beat_cnt"}, 64'(beat_cnt), 64'(beats));
        chk({name, "_ar_left"}, 64'(exp_ar_addr.size()), 64'd0);
        chk({name, "_data_left"}, 64'(exp_data.size()), 64'd0);
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_outputs", 64'({arvalid, rready, tvalid, tlast, done, busy, err, status}), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_arsize", 64'(arsize), 64'd3);
        chk("rst_arburst", 64'(arburst), 64'd1);
        arest_n = 1'b1;
        @(posedge aclk);
        #1;

        // 1 KB aligned: eight full bursts
        new_test();
        for (int i = 0; i < 8; i++) exp_burst(32'h1000_0000 + 32'(i * 'h80), 16, i == 7);
        pulse_start(32'h1000_0000, 32'd1024);
        chk("ar_latency", 64'(arvalid), 64'd1);
        chk("busy_running", 64'(busy), 64'd1);
        wait_done("aligned");
        finish_test("aligned", 128);

        // Start near a page end: 8 + 16 + 8 beats
        new_test();
        exp_burst(32'h1000_0FC0, 8, 1'b0);
        exp_burst(32'h1000_1000, 16, 1'b0);
        exp_burst(32'h1000_1080, 8, 1'b1);
        pulse_start(32'h1000_0FC0, 32'd256);
        wait_done("page");
        finish_test("page", 32);

        // Zero beats: done the cycle after start, no AR
        new_test();
        pulse_start(32'h1000_0000, 32'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_status", 64'(status), 64'h3);
        @(posedge aclk);
        #1;
        chk("zero_done_clr", 64'(done), 64'd0);
        chk("zero_busy_clr", 64'(busy), 64'd0);
        finish_test("zero", 0);

        new_test();
        pulse_start(32'h1000_0003, 32'd7);
        chk("len7_done", 64'(done), 64'd1);
        finish_test("len7", 0);

        // Random stalls, unaligned start, ignored mid-transfer start
        new_test();
        stall_en = 1'b1;
        exp_burst(32'h2000_0000, 16, 1'b0);
        exp_burst(32'h2000_0080, 16, 1'b0);
        exp_burst(32'h2000_0100, 5, 1'b1);
        pulse_start(32'h2000_0004, 32'd300);
        wait_beats("stall", 10);
        pulse_start(32'h5000_0000, 32'd64);
        wait_done("stall");
        stall_en = 1'b0;
        finish_test("stall", 37);

        // Stop during the second burst
        new_test();
        exp_burst(32'h3000_0000, 16, 1'b0);
        exp_burst(32'h3000_0080, 16, 1'b0);
        pulse_start(32'h3000_0000, 32'd1024);
        wait_beats("stop", 20);
        stop = 1'b1;
        wait_done("stop");
        finish_test("stop", 32);
        stop = 1'b0;

        // SLVERR on the fifth beat
        new_test();
        err_beat = 4;
        exp_err  = 1'b1;
        exp_burst(32'h4000_0000, 16, 1'b1);
        pulse_start(32'h4000_0000, 32'd128);
        wait_done("slverr");
        finish_test("slverr", 16);
        chk("err_sticky", 64'(err), 64'd1);
        err_beat = -1;
        exp_err  = 1'b0;
        new_test();
        pulse_start(32'h4000_0000, 32'd0);
        chk("err_cleared", 64'(err), 64'd0);
        finish_test("errclr", 0);

        // Asynchronous reset in the middle of a burst
        new_test();
        exp_burst(32'h6000_0000, 16, 1'b1);
        pulse_start(32'h6000_0000, 32'd128);
        wait_beats("arst", 5);
        #3;
        arest_n = 1'b0;
        #1;
        chk("arst_outputs", 64'({arvalid, rready, tvalid, tlast, done, busy, err, status}), 64'd0);
        chk("arst_araddr", 64'(araddr), 64'd0);
        chk("arst_arlen", 64'(arlen), 64'd0);
        chk("arst_tdata", tdata, 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        exp_ar_addr.delete();
        exp_ar_len.delete();
        exp_data.delete();
        exp_last.delete();
        arest_n = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("arst_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
